// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one multi-cycle memory port between instruction fetch and the
//   data load/store unit. One transaction is latched at a time. The memory
//   port is driven until mem_ack, and the read data is returned (registered)
//   to the requester that owns the transaction.
//
//   Optional build macro:
//     MEM_ARB_RR_EN - round-robin arbitration on contention. When it is not
//                     defined, data requests always win on contention.
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   if_req/if_addr                fetch request in
//   if_gnt/if_rvalid/if_rdata     fetch accept pulse, data pulse, data
//   d_req/d_we/d_be/d_addr/d_wdata data request in
//   d_gnt/d_rvalid/d_rdata        data accept pulse, completion pulse, load data
//   mem_req/we/be/addr/wdata      memory request, held until mem_ack
//   mem_ack/mem_rdata             memory completion and read data
//   busy                          a transaction is in flight
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;
    state_t state;

    logic grant_if, grant_d;

`ifdef MEM_ARB_RR_EN
    // 1 = data was granted last, 0 = fetch was granted last.
    logic last_d;

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state == IDLE) begin
            if (if_req && d_req) begin
                grant_d  = !last_d;
                grant_if = last_d;
            end else begin
                grant_d  = d_req;
                grant_if = if_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            last_d <= 1'b0;
        else if (grant_d)
            last_d <= 1'b1;
        else if (grant_if)
            last_d <= 1'b0;
    end
`else
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state == IDLE) begin
            grant_d  = d_req;
            grant_if = if_req && !d_req;
        end
    end
`endif

    assign if_gnt = grant_if;
    assign d_gnt  = grant_d;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    // mem_ack here is stray and deliberately ignored.
                    if (grant_d) begin
                        state     <= D_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_be    <= d_be;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (grant_if) begin
                        state     <= IF_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= '1;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                IF_BUSY, D_BUSY: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (state == IF_BUSY) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end else begin
                            d_rvalid  <= 1'b1;
                            // Stores complete with zero data.
                            d_rdata   <= mem_we ? '0 : mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack, busy;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_d;

    initial begin
        rst = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
        d_addr = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
        tick(); tick();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        rst = 1'b1;
        tick();

        // Single fetch, zero-wait memory.
        if_req = 1; if_addr = 32'h4; #1;
        chk("f_gnt", {31'd0, if_gnt}, 32'd1);
        chk("f_dgnt", {31'd0, d_gnt}, 32'd0);
        tick();
        if_req = 0;
        chk("f_mem_req", {31'd0, mem_req}, 32'd1);
        chk("f_busy", {31'd0, busy}, 32'd1);
        chk("f_mem_addr", mem_addr, 32'h4);
        chk("f_mem_we", {31'd0, mem_we}, 32'd0);
        chk("f_mem_be", {28'd0, mem_be}, 32'hF);
        mem_ack = 1; mem_rdata = 32'h0050_0093;
        tick();
        mem_ack = 0; mem_rdata = 0;
        chk("f_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("f_rdata", if_rdata, 32'h0050_0093);
        chk("f_mem_req_off", {31'd0, mem_req}, 32'd0);
        chk("f_busy_off", {31'd0, busy}, 32'd0);
        tick();
        chk("f_rvalid_pulse", {31'd0, if_rvalid}, 32'd0);

        // Store with three wait cycles.
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; #1;
        chk("s_gnt", {31'd0, d_gnt}, 32'd1);
        tick();
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 4; i++) begin
            chk("s_mem_req", {31'd0, mem_req}, 32'd1);
            chk("s_mem_we", {31'd0, mem_we}, 32'd1);
            chk("s_mem_be", {28'd0, mem_be}, 32'h3);
            chk("s_mem_addr", mem_addr, 32'h100);
            chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("s_no_rvalid", {31'd0, d_rvalid}, 32'd0);
            if (i == 3) begin
                mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
            end
            tick();
        end
        mem_ack = 0; mem_rdata = 0;
        chk("s_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("s_rdata_zero", d_rdata, 32'd0);
        chk("s_mem_req_off", {31'd0, mem_req}, 32'd0);
        chk("s_if_rdata_hold", if_rdata, 32'h0050_0093);
        chk("s_if_rvalid", {31'd0, if_rvalid}, 32'd0);

        // Load with request held for one cycle only.
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200; #1;
        chk("l_gnt", {31'd0, d_gnt}, 32'd1);
        tick();
        d_req = 0;
        chk("l_mem_req", {31'd0, mem_req}, 32'd1);
        chk("l_mem_addr", mem_addr, 32'h200);
        tick();
        chk("l_wait", {31'd0, mem_req}, 32'd1);
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 0; mem_rdata = 0;
        chk("l_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("l_rdata", d_rdata, 32'hCAFE_F00D);
        chk("l_no_regnt", {31'd0, d_gnt}, 32'd0);
        tick();
        chk("l_idle", {31'd0, busy}, 32'd0);
        chk("l_no_req", {31'd0, mem_req}, 32'd0);

        // Stray mem_ack while idle.
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 0; mem_rdata = 0;
        chk("x_busy", {31'd0, busy}, 32'd0);
        chk("x_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("x_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("x_d_rdata", d_rdata, 32'hCAFE_F00D);
        chk("x_if_rdata", if_rdata, 32'h0050_0093);

        // Reset in the middle of a data transaction, late ack afterwards.
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h240; #1;
        chk("r_gnt", {31'd0, d_gnt}, 32'd1);
        tick();
        d_req = 0;
        chk("r_busy_pre", {31'd0, busy}, 32'd1);
        rst = 0;
        tick();
        rst = 1;
        chk("r_mem_req", {31'd0, mem_req}, 32'd0);
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_rvalid", {31'd0, d_rvalid}, 32'd0);
        mem_ack = 1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 0; mem_rdata = 0;
        chk("r_late_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("r_late_busy", {31'd0, busy}, 32'd0);
        chk("r_d_rdata", d_rdata, 32'd0);

        // Contention: both requests held across four transactions.
`ifdef MEM_ARB_RR_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        if_req = 1; if_addr = 32'h8;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("c%0d_dgnt", k), {31'd0, d_gnt}, {31'd0, exp_d[k]});
            chk($sformatf("c%0d_ifgnt", k), {31'd0, if_gnt}, {31'd0, !exp_d[k]});
            tick();
            chk($sformatf("c%0d_addr", k), mem_addr, exp_d[k] ? 32'h300 : 32'h8);
            mem_ack = 1; mem_rdata = 32'h1000 + k;
            tick();
            mem_ack = 0; mem_rdata = 0;
            if (k == 3) begin
                if_req = 0; d_req = 0;
            end
            if (exp_d[k]) begin
                chk($sformatf("c%0d_d_rvalid", k), {31'd0, d_rvalid}, 32'd1);
                chk($sformatf("c%0d_d_rdata", k), d_rdata, 32'h1000 + k);
            end else begin
                chk($sformatf("c%0d_if_rvalid", k), {31'd0, if_rvalid}, 32'd1);
                chk($sformatf("c%0d_if_rdata", k), if_rdata, 32'h1000 + k);
            end
        end
        tick();
        chk("c_end_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one unified memory port between instruction fetch and data load/store in the RV32I core. Sits between the PC/instruction-fetch path, the datapath load/store unit, and a single multi-cycle memory with a request/acknowledge handshake. It latches one request at a time, drives the memory port until acknowledge, returns registered read data to the owner, and reports `busy` so the core can stall the PC.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (multiple of 8)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous reset, active-low (0 = reset)
- `if_req`  in  1  fetch request
- `if_addr`  in  AW  fetch address
- `if_gnt`  out  1  fetch request accepted (1-cycle pulse)
- `if_rvalid`  out  1  fetch data valid (1-cycle pulse)
- `if_rdata`  out  DW  fetched instruction
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_be`  in  DW/8  byte enables
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_gnt`  out  1  data request accepted (1-cycle pulse)
- `d_rvalid`  out  1  data transaction complete (1-cycle pulse, loads and stores)
- `d_rdata`  out  DW  load data; 0 on store completion
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/DW/8/AW/DW  latched transaction fields
- `mem_ack`  in  1  memory completion; `mem_rdata` valid this cycle
- `mem_rdata`  in  DW  memory read data
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, IF_BUSY, D_BUSY.
- IDLE: if any request, grant one: pulse its `*_gnt` combinationally in this cycle, latch addr/we/be/wdata (fetch: we=0, be=all ones), go to the owner's BUSY state. No request: stay.
- Contention (both requests in IDLE): arbitration policy per Configuration.
- IF_BUSY / D_BUSY: `mem_req`=1 with latched fields stable. On `mem_ack`: capture `mem_rdata` (or 0 for stores) into the owner's `*_rdata`, pulse the owner's `*_rvalid` in the next cycle, go to IDLE.
- `*_rdata` holds the last value until the next completion for that requester.
- Requester may drop `*_req` after `*_gnt`; the latched transaction completes regardless.
- `*_gnt` never asserts outside IDLE; requests arriving while BUSY wait.
- `mem_ack` while IDLE is ignored: no state change, no `rvalid`.
- `mem_*` outputs are 0 in IDLE.

## Timing
- Reset (rst=0 at edge): state IDLE; `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `if_rvalid`, `d_rvalid`, `if_rdata`, `d_rdata`, `busy` = 0; round-robin pointer = "last granted fetch".
- Reset mid-transaction: next cycle IDLE, `mem_req`=0, no `rvalid`; a late `mem_ack` is ignored.
- Grant cycle T (IDLE, req=1): `gnt`=1 at T; `mem_req`=1 and `busy`=1 from T+1.
- `mem_ack` at cycle A: `mem_req` 0 from A+1; `rvalid` and new `rdata` at A+1, state IDLE at A+1; the next grant is possible at A+1.
- Zero-wait memory (`mem_ack` in first request cycle): 2 cycles per transaction, request-to-data latency 2.
- `rvalid` for a transaction and `gnt` for the next may coincide at A+1.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin on contention. Grant the requester not granted last; 1-bit pointer updated on every grant. First contention after reset grants data.
- Undefined: fixed priority, data always wins on contention. The pointer is not implemented.
- Uncontended behaviour is identical in both builds.

## Test plan
- Reset: drive rst=0 mid-D_BUSY with `mem_ack`=1 next cycle -> `mem_req`=0, `d_rvalid` never pulses, `busy`=0.
- Single fetch, zero-wait: `if_req`, `if_addr`=0x0000_0004 at T; `mem_ack`, `mem_rdata`=0x0050_0093 at T+1 -> `if_gnt`@T, `mem_addr`=0x4 @T+1, `if_rvalid`=1 and `if_rdata`=0x0050_0093 @T+2.
- Store, 3 wait cycles: `d_we`=1, `d_be`=4'b0011, `d_addr`=0x100, `d_wdata`=0xDEAD_BEEF -> `mem_req` held 4 cycles with stable fields, `d_rvalid`@ack+1, `d_rdata`=0.
- Contention, both requests held for 4 transactions -> without macro: D,D,D,D; with `MEM_ARB_RR_EN`: D,IF,D,IF.
- Request drop: `d_req` high 1 cycle only -> load still completes with `d_rvalid`=1 and correct data; no second grant.
- Spurious `mem_ack` in IDLE with `mem_rdata`=0x1234_5678 -> no `rvalid`, `*_rdata` unchanged.
